// File: rtl/collector_uart.sv
// 8N1 UART receiver with a one-entry AXI-stream-style output register.
// Samples mid-bit from a 2-flop synchronised line; flags overruns and bad stop bits.
module collector_uart #(
  parameter int unsigned clk_freq_hz = 25_000_000,
  parameter int unsigned baud_rate   = 57600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_uart_rx,
  output logic [7:0] o_tdata,
  output logic       o_tvalid,
  input  logic       i_tready,
  output logic       o_overrun,
  output logic       o_frame_err
);

  localparam int unsigned CLKS  = clk_freq_hz / baud_rate;
  localparam int unsigned CW    = (CLKS > 2) ? $clog2(CLKS) : 1;
  localparam int unsigned HALF  = CLKS / 2 - 1;
  localparam int unsigned FULL  = CLKS - 1;
  localparam int unsigned DBITS = 8;
  localparam int unsigned BW    = $clog2(DBITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic              rx_meta, rx_s;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DBITS-1:0]  shift_q, shift_d;
  logic [DBITS-1:0]  tdata_d;
  logic              tvalid_d;
  logic              overrun_d;
  logic              frame_err_d;
  logic              expire_c;

  // Line is idle high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

  assign expire_c = (cnt_q == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      o_tdata     <= '0;
      o_tvalid    <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      o_tdata     <= tdata_d;
      o_tvalid    <= tvalid_d;
      o_overrun   <= overrun_d;
      o_frame_err <= frame_err_d;
    end
  end

  // Next-state, baud timing and output-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = expire_c ? cnt_q : cnt_q - CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    tdata_d     = o_tdata;
    tvalid_d    = o_tvalid && !i_tready;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_d   = CW'(HALF);
          state_d = S_START;
        end
      end
      S_START: begin
        if (expire_c) begin
          if (!rx_s) begin
            cnt_d   = CW'(FULL);
            bit_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (expire_c) begin
          shift_d = {rx_s, shift_q[DBITS-1:1]};
          cnt_d   = CW'(FULL);
          bit_d   = BW'(bit_q + BW'(1));
          if (bit_q == BW'(DBITS - 1)) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (expire_c) begin
          if (rx_s) begin
            if (!o_tvalid || i_tready) begin
              tdata_d  = shift_q;
              tvalid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_collector_uart.sv
// Directed bench for collector_uart: table of single-byte receptions plus
// hand-written overrun, glitch, framing, reset and load/transfer-collision sequences.
module tb_collector_uart;

  localparam int unsigned CLK_HZ = 25_000_000;
  localparam int unsigned BAUD   = 57600;
  localparam int unsigned CLKS   = CLK_HZ / BAUD;
  localparam int unsigned LAT    = 2 + CLKS / 2 + 9 * CLKS + 1;

  typedef struct {
    logic [7:0] data;
    int         bitclk;
    bit         chk_lat;
    logic [7:0] exp_data;
  } vec_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_uart_rx = 1'b1;
  logic       i_tready = 1'b1;
  logic [7:0] o_tdata;
  logic       o_tvalid;
  logic       o_overrun;
  logic       o_frame_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0] rx_q[$];
  int ovr_cnt = 0, fe_cnt = 0, rise_cnt = 0, hi_cnt = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  int q0, o0, f0, r0, h0, c0, d;
  vec_t vecs[4];

  collector_uart #(
    .clk_freq_hz(CLK_HZ),
    .baud_rate  (BAUD)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_uart_rx  (i_uart_rx),
    .o_tdata    (o_tdata),
    .o_tvalid   (o_tvalid),
    .i_tready   (i_tready),
    .o_overrun  (o_overrun),
    .o_frame_err(o_frame_err)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Observe outputs on the falling edge, half a cycle away from updates.
  always @(negedge i_clk) begin
    if (o_tvalid && i_tready) rx_q.push_back(o_tdata);
    if (o_overrun) ovr_cnt++;
    if (o_frame_err) fe_cnt++;
    if (o_tvalid && !prev_valid) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (o_tvalid) hi_cnt++;
    prev_valid = o_tvalid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge i_clk);
    #1;
  endtask

  task automatic snap();
    q0 = rx_q.size();
    o0 = ovr_cnt;
    f0 = fe_cnt;
    r0 = rise_cnt;
    h0 = hi_cnt;
  endtask

  // Caller must be 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int bitclk, input bit stop_ok);
    i_uart_rx = 1'b0;
    repeat (bitclk) @(posedge i_clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      i_uart_rx = b[i];
      repeat (bitclk) @(posedge i_clk);
      #1;
    end
    i_uart_rx = stop_ok;
    repeat (bitclk) @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [7:0] b96;
    vecs[0] = '{8'hA5, int'(CLKS), 1'b1, 8'hA5};
    vecs[1] = '{8'h69, int'(CLKS), 1'b1, 8'h69};
    vecs[2] = '{8'hA5, int'(CLK_HZ / (BAUD * 102 / 100)), 1'b0, 8'hA5};
    vecs[3] = '{8'hA5, int'(CLK_HZ / (BAUD * 98 / 100)), 1'b0, 8'hA5};

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_tvalid", 32'(o_tvalid), 32'd0);
    chk("rst_tdata", 32'(o_tdata), 32'd0);
    chk("rst_overrun", 32'(o_overrun), 32'd0);
    chk("rst_frame_err", 32'(o_frame_err), 32'd0);
    i_rst_n = 1'b1;
    repeat (10) @(posedge i_clk);

    // Single bytes, consumer always ready.
    for (int k = 0; k < 4; k++) begin
      snap();
      sync();
      c0 = cyc;
      send_byte(vecs[k].data, vecs[k].bitclk, 1'b1);
      repeat (20) @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_count", k), 32'(rx_q.size() - q0), 32'd1);
      if (rx_q.size() > q0) chk($sformatf("vec%0d_data", k), 32'(rx_q[q0]), 32'(vecs[k].exp_data));
      chk($sformatf("vec%0d_valid_cycles", k), 32'(hi_cnt - h0), 32'd1);
      chk($sformatf("vec%0d_overrun", k), 32'(ovr_cnt - o0), 32'd0);
      chk($sformatf("vec%0d_frame_err", k), 32'(fe_cnt - f0), 32'd0);
      if (vecs[k].chk_lat) begin
        d = rise_cyc - c0;
        checks++;
        if (d < int'(LAT) - 2 || d > int'(LAT) + 2) begin
          errors++;
          $display("FAIL vec%0d_latency: got %0d cycles, expected %0d +/-2", k, d, LAT);
        end
      end
    end

    // Overrun: held byte survives, later bytes dropped.
    i_tready = 1'b0;
    snap();
    sync();
    send_byte(8'h00, int'(CLKS), 1'b1);
    send_byte(8'hFF, int'(CLKS), 1'b1);
    send_byte(8'h55, int'(CLKS), 1'b1);
    repeat (20) @(posedge i_clk);
    #1;
    chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd2);
    chk("ovr_tdata", 32'(o_tdata), 32'h00);
    chk("ovr_tvalid", 32'(o_tvalid), 32'd1);
    i_tready = 1'b1;
    sync();
    chk("ovr_drain_tvalid", 32'(o_tvalid), 32'd0);
    chk("ovr_drain_count", 32'(rx_q.size() - q0), 32'd1);
    if (rx_q.size() > q0) chk("ovr_drain_data", 32'(rx_q[q0]), 32'h00);

    // Short low glitch must be ignored.
    snap();
    i_uart_rx = 1'b0;
    repeat (100) @(posedge i_clk);
    #1;
    i_uart_rx = 1'b1;
    repeat (1000) @(posedge i_clk);
    #1;
    chk("glitch_no_valid", 32'(rise_cnt - r0), 32'd0);
    chk("glitch_no_fe", 32'(fe_cnt - f0), 32'd0);
    send_byte(8'h3C, int'(CLKS), 1'b1);
    repeat (20) @(posedge i_clk);
    #1;
    chk("glitch_count", 32'(rx_q.size() - q0), 32'd1);
    if (rx_q.size() > q0) chk("glitch_data", 32'(rx_q[q0]), 32'h3C);

    // Framing error followed by a long break, then a good byte left held.
    i_tready = 1'b0;
    snap();
    send_byte(8'h81, int'(CLKS), 1'b0);
    repeat (2000) @(posedge i_clk);
    #1;
    i_uart_rx = 1'b1;
    repeat (CLKS) @(posedge i_clk);
    #1;
    send_byte(8'h42, int'(CLKS), 1'b1);
    repeat (20) @(posedge i_clk);
    #1;
    chk("fe_pulses", 32'(fe_cnt - f0), 32'd1);
    chk("fe_valid_rises", 32'(rise_cnt - r0), 32'd1);
    chk("fe_tdata", 32'(o_tdata), 32'h42);
    chk("fe_tvalid", 32'(o_tvalid), 32'd1);

    // Reset asserted during data bit 4 clears outputs without a clock edge.
    b96 = 8'h96;
    i_uart_rx = 1'b0;
    repeat (CLKS) @(posedge i_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      i_uart_rx = b96[i];
      repeat (CLKS) @(posedge i_clk);
      #1;
    end
    i_uart_rx = b96[4];
    repeat (CLKS / 2) @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", 32'(o_tvalid), 32'd0);
    chk("midrst_tdata", 32'(o_tdata), 32'd0);
    chk("midrst_overrun", 32'(o_overrun), 32'd0);
    chk("midrst_frame_err", 32'(o_frame_err), 32'd0);
    i_uart_rx = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    i_tready = 1'b1;
    repeat (CLKS) @(posedge i_clk);
    #1;
    snap();
    send_byte(8'h96, int'(CLKS), 1'b1);
    repeat (20) @(posedge i_clk);
    #1;
    chk("midrst_count", 32'(rx_q.size() - q0), 32'd1);
    if (rx_q.size() > q0) chk("midrst_data", 32'(rx_q[q0]), 32'h96);

    // Ready rises exactly on the edge that loads the next byte.
    i_tready = 1'b0;
    send_byte(8'h11, int'(CLKS), 1'b1);
    repeat (CLKS) @(posedge i_clk);
    snap();
    sync();
    fork
      send_byte(8'h22, int'(CLKS), 1'b1);
      begin
        repeat (LAT - 1) @(posedge i_clk);
        #1;
        i_tready = 1'b1;
        @(posedge i_clk);
        #1;
        i_tready = 1'b0;
      end
    join
    repeat (20) @(posedge i_clk);
    #1;
    chk("coll_count", 32'(rx_q.size() - q0), 32'd1);
    if (rx_q.size() > q0) chk("coll_xfer_data", 32'(rx_q[q0]), 32'h11);
    chk("coll_tdata", 32'(o_tdata), 32'h22);
    chk("coll_tvalid", 32'(o_tvalid), 32'd1);
    chk("coll_overrun", 32'(ovr_cnt - o0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
